// File: rtl/flatten_serializer_pkg.sv
// Shared CNN constants and helpers for the flatten stage and its neighbours
// (GAP units upstream, fully-connected/softmax unit downstream).
package flatten_serializer_pkg;

    localparam int DATA_W      = 8;
    localparam int GAP_CH      = 32;
    localparam int FC_IN_DIM   = 32;
    localparam int QUANT_SHIFT = 8;

    // Index width for n elements; a single-element vector still needs one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/flatten_serializer_if.sv
// Vector-in / element-out stream bundle of the flatten stage.
// slave is the serializer's view, master is the view of its surroundings.
interface flatten_serializer_if #(
    parameter int CH = 32,
    parameter int DW = 8
);
    localparam int IDX_W = flatten_serializer_pkg::clog2_min1(CH);

    logic                 in_valid;
    logic [CH*DW-1:0]     in_data;
    logic                 in_ready;
    logic                 out_valid;
    logic [DW-1:0]        out_data;
    logic [IDX_W-1:0]     out_index;
    logic                 out_last;
    logic                 out_ready;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_index, out_last
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_index, out_last
    );

endinterface

// File: rtl/flatten_serializer.sv
// Ping-pong double-buffered flatten stage: captures a CH-wide vector in one
// cycle and streams its elements (element 0 first) over valid/ready.
module flatten_serializer
    import flatten_serializer_pkg::*;
#(
    parameter int CH = GAP_CH,
    parameter int DW = DATA_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    flatten_serializer_if.slave   bus,
    output logic                  overrun,
    output logic                  busy
);

    localparam int              IDX_W    = clog2_min1(CH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CH - 1);

    logic [DW-1:0]    r_bank [2][CH];
    logic [1:0]       r_full;
    logic             r_wr_bank;
    logic             r_rd_bank;
    logic [IDX_W-1:0] r_idx;
    logic             r_overrun;

    logic w_in_ready;
    logic w_out_valid;
    logic w_at_last;
    logic w_beat;
    logic w_last_beat;
    logic w_capture;
    logic w_drop;

    // Readiness depends only on the full flags, so out_ready never reaches in_ready.
    assign w_in_ready  = ~r_full[r_wr_bank];
    assign w_out_valid = r_full[r_rd_bank];
    assign w_at_last   = (r_idx == LAST_IDX);
    assign w_beat      = w_out_valid & bus.out_ready;
    assign w_last_beat = w_beat & w_at_last;
    assign w_capture   = bus.in_valid & w_in_ready & ~clear;
    assign w_drop      = bus.in_valid & ~w_in_ready & ~clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int k = 0; k < CH; k++) begin
                    r_bank[b][k] <= '0;
                end
            end
        end else if (w_capture) begin
            for (int k = 0; k < CH; k++) begin
                r_bank[r_wr_bank][k] <= bus.in_data[k*DW +: DW];
            end
        end
    end

    // A capture and a final beat always target different banks, so both
    // full-flag updates can land in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full    <= '0;
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
            r_idx     <= '0;
            r_overrun <= 1'b0;
        end else if (clear) begin
            r_full    <= '0;
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
            r_idx     <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_capture) begin
                r_full[r_wr_bank] <= 1'b1;
                r_wr_bank         <= ~r_wr_bank;
            end
            if (w_drop) begin
                r_overrun <= 1'b1;
            end
            if (w_last_beat) begin
                r_full[r_rd_bank] <= 1'b0;
                r_rd_bank         <= ~r_rd_bank;
                r_idx             <= '0;
            end else if (w_beat) begin
                r_idx <= r_idx + IDX_W'(1);
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = r_bank[r_rd_bank][r_idx];
    assign bus.out_index = r_idx;
    assign bus.out_last  = w_out_valid & w_at_last;
    assign overrun       = r_overrun;
    assign busy          = |r_full;

endmodule

// File: tb/tb_flatten_serializer.sv
// Bench for flatten_serializer: queue-based vector model with per-cycle
// comparison, directed scenarios and a randomized traffic phase.
module tb_flatten_serializer;
    import flatten_serializer_pkg::*;

    localparam int CH  = 32;
    localparam int DW  = 8;
    localparam int CH2 = 4;
    localparam int DW2 = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;
    logic clear2 = 1'b0;
    logic ovr1, busy1, ovr2, busy2;

    always #5 clk = ~clk;

    flatten_serializer_if #(.CH(CH),  .DW(DW))  bus1 ();
    flatten_serializer_if #(.CH(CH2), .DW(DW2)) bus2 ();

    flatten_serializer #(.CH(CH), .DW(DW)) dut1 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus1.slave),
        .overrun(ovr1), .busy(busy1)
    );

    flatten_serializer #(.CH(CH2), .DW(DW2)) dut2 (
        .clk(clk), .rst_n(rst_n), .clear(clear2), .bus(bus2.slave),
        .overrun(ovr2), .busy(busy2)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [15:0] d;
        int          idx;
        bit          last;
        int          cyc;
    } beat_t;

    beat_t log1[$];
    beat_t log2[$];

    always @(posedge clk) cyc++;

    // Reference model: a queue of at most two pending vectors plus the position
    // of the next element to send from the oldest one.
    logic [CH*DW-1:0] mq[$];
    int               mpos;
    bit               movr;
    bit               m_beat, m_cap, m_drop;
    logic [CH*DW-1:0] m_vec;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            mpos = 0;
            movr = 0;
        end else begin
            m_beat = (mq.size() > 0) && bus1.out_ready;
            m_cap  = bus1.in_valid && (mq.size() < 2) && !clear;
            m_drop = bus1.in_valid && (mq.size() == 2) && !clear;
            if (clear) begin
                mq.delete();
                mpos = 0;
                movr = 0;
            end else begin
                if (m_beat) begin
                    if (mpos == CH - 1) begin
                        void'(mq.pop_front());
                        mpos = 0;
                    end else begin
                        mpos++;
                    end
                end
                if (m_cap)  mq.push_back(bus1.in_data);
                if (m_drop) movr = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("out_valid", 64'(bus1.out_valid), 64'(mq.size() > 0));
            check("in_ready",  64'(bus1.in_ready),  64'(mq.size() < 2));
            check("busy",      64'(busy1),          64'(mq.size() > 0));
            check("overrun",   64'(ovr1),           64'(movr));
            if (mq.size() > 0) begin
                m_vec = mq[0];
                check("out_data",  64'(bus1.out_data),  64'(m_vec[mpos*DW +: DW]));
                check("out_index", 64'(bus1.out_index), 64'(mpos));
                check("out_last",  64'(bus1.out_last),  64'(mpos == CH - 1));
            end else begin
                check("out_last_idle", 64'(bus1.out_last), 64'(0));
            end
            if (bus1.out_valid && bus1.out_ready)
                log1.push_back('{d: 16'(bus1.out_data), idx: int'(bus1.out_index),
                                 last: bus1.out_last, cyc: cyc});
            if (bus2.out_valid && bus2.out_ready)
                log2.push_back('{d: bus2.out_data, idx: int'(bus2.out_index),
                                 last: bus2.out_last, cyc: cyc});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_log1(input int n, input int budget);
        for (int i = 0; i < budget && log1.size() < n; i++) tick();
        check("beat_count", 64'(log1.size()), 64'(n));
    endtask

    function automatic logic [CH*DW-1:0] ramp(input int base, input int step);
        logic [CH*DW-1:0] v;
        for (int k = 0; k < CH; k++) v[k*DW +: DW] = DW'(base + k * step);
        return v;
    endfunction

    // Beats log1[start .. start+CH-1] must carry base, base+step, ... in order.
    task automatic check_seq(input string name, input int start, input int base, input int step);
        for (int k = 0; k < CH; k++) begin
            if (start + k >= log1.size()) begin
                check({name, "_missing"}, 64'(log1.size()), 64'(start + CH));
                return;
            end
            check({name, "_data"},  64'(log1[start+k].d),    64'((base + k * step) & 8'hFF));
            check({name, "_index"}, 64'(log1[start+k].idx),  64'(k));
            check({name, "_last"},  64'(log1[start+k].last), 64'(k == CH - 1));
        end
    endtask

    task automatic present1(input logic [CH*DW-1:0] v);
        bus1.in_data  = v;
        bus1.in_valid = 1'b1;
        tick();
        bus1.in_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [CH*DW-1:0] rv;
        bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.out_ready = 1'b0;
        bus2.in_valid = 1'b0; bus2.in_data = '0; bus2.out_ready = 1'b0;

        #1;
        check("rst_out_valid", 64'(bus1.out_valid), 64'(0));
        check("rst_out_data",  64'(bus1.out_data),  64'(0));
        check("rst_out_index", 64'(bus1.out_index), 64'(0));
        check("rst_out_last",  64'(bus1.out_last),  64'(0));
        check("rst_overrun",   64'(ovr1),           64'(0));
        check("rst_busy",      64'(busy1),          64'(0));
        check("rst_in_ready",  64'(bus1.in_ready),  64'(1));
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Single vector, free-running sink
        bus1.out_ready = 1'b1;
        log1.delete();
        check("t1_in_ready", 64'(bus1.in_ready), 64'(1));
        present1(ramp(1, 1));
        check("t1_valid_next", 64'(bus1.out_valid), 64'(1));
        check("t1_first_data", 64'(bus1.out_data),  64'(1));
        wait_log1(32, 40);
        check_seq("t1", 0, 1, 1);
        tick();
        check("t1_valid_end", 64'(bus1.out_valid), 64'(0));
        check("t1_busy_end",  64'(busy1),          64'(0));

        // Alternating backpressure
        log1.delete();
        bus1.out_ready = 1'b1;
        present1(ramp(1, 1));
        for (int i = 0; i < 63; i++) begin
            tick();
            bus1.out_ready = ~bus1.out_ready;
        end
        check("t2_valid_end", 64'(bus1.out_valid), 64'(0));
        check_seq("t2", 0, 1, 1);
        if (log1.size() == 32)
            check("t2_span", 64'(log1[31].cyc - log1[0].cyc), 64'(62));
        bus1.out_ready = 1'b1;
        tick();

        // Back-to-back vectors, no bubble between them
        log1.delete();
        bus1.in_data = {CH{8'h11}};
        bus1.in_valid = 1'b1;
        tick();
        check("t3_b_ready", 64'(bus1.in_ready), 64'(1));
        bus1.in_data = {CH{8'h22}};
        tick();
        bus1.in_valid = 1'b0;
        wait_log1(64, 80);
        check_seq("t3a", 0, 8'h11, 0);
        check_seq("t3b", 32, 8'h22, 0);
        if (log1.size() == 64)
            check("t3_span", 64'(log1[63].cyc - log1[0].cyc), 64'(63));
        tick();

        // Overrun with both banks held, then soft clear
        log1.delete();
        bus1.out_ready = 1'b0;
        present1(ramp(1, 1));
        present1(ramp(8'h40, 1));
        bus1.in_data  = ramp(8'h80, 1);
        bus1.in_valid = 1'b1;
        check("t4_c_ready", 64'(bus1.in_ready), 64'(0));
        tick();
        bus1.in_valid = 1'b0;
        check("t4_overrun", 64'(ovr1), 64'(1));
        bus1.out_ready = 1'b1;
        wait_log1(64, 80);
        check_seq("t4a", 0, 1, 1);
        check_seq("t4b", 32, 8'h40, 1);
        tick();
        check("t4_valid_drained", 64'(bus1.out_valid), 64'(0));
        check("t4_overrun_held",  64'(ovr1),           64'(1));
        clear = 1'b1;
        bus1.in_valid = 1'b1;
        tick();
        clear = 1'b0;
        bus1.in_valid = 1'b0;
        check("t4_clr_overrun",  64'(ovr1),           64'(0));
        check("t4_clr_valid",    64'(bus1.out_valid), 64'(0));
        check("t4_clr_in_ready", 64'(bus1.in_ready),  64'(1));

        // Asynchronous reset in the middle of a stream
        log1.delete();
        present1(ramp(5, 3));
        wait_log1(10, 20);
        #2 rst_n = 1'b0;
        #1;
        check("t5_valid", 64'(bus1.out_valid), 64'(0));
        check("t5_data",  64'(bus1.out_data),  64'(0));
        check("t5_index", 64'(bus1.out_index), 64'(0));
        check("t5_last",  64'(bus1.out_last),  64'(0));
        check("t5_busy",  64'(busy1),          64'(0));
        check("t5_ready", 64'(bus1.in_ready),  64'(1));
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        log1.delete();
        present1(ramp(9, 2));
        wait_log1(32, 40);
        check_seq("t5", 0, 9, 2);

        // Narrow instance, 4 x 16 bit
        bus2.out_ready = 1'b1;
        bus2.in_data   = {16'hABCD, 16'h0003, 16'h0002, 16'h0001};
        bus2.in_valid  = 1'b1;
        tick();
        bus2.in_valid = 1'b0;
        for (int i = 0; i < 10 && log2.size() < 4; i++) tick();
        check("t6_count", 64'(log2.size()), 64'(4));
        if (log2.size() == 4) begin
            check("t6_d0", 64'(log2[0].d), 64'(16'h0001));
            check("t6_d1", 64'(log2[1].d), 64'(16'h0002));
            check("t6_d2", 64'(log2[2].d), 64'(16'h0003));
            check("t6_d3", 64'(log2[3].d), 64'(16'hABCD));
            for (int k = 0; k < 4; k++) begin
                check("t6_index", 64'(log2[k].idx),  64'(k));
                check("t6_last",  64'(log2[k].last), 64'(k == 3));
            end
        end
        tick();
        check("t6_busy_end",    64'(busy2), 64'(0));
        check("t6_overrun_end", 64'(ovr2),  64'(0));

        // Randomized traffic: bursts of vectors, random sink stalls, rare clears
        for (int i = 0; i < 3000; i++) begin
            for (int w = 0; w < CH * DW / 32; w++) rv[w*32 +: 32] = $urandom();
            bus1.in_data   = rv;
            bus1.in_valid  = ($urandom_range(0, 19) == 0);
            bus1.out_ready = ($urandom_range(0, 3) != 0) || (i % 500 > 400);
            clear          = ($urandom_range(0, 599) == 0);
            tick();
        end
        bus1.in_valid  = 1'b0;
        clear          = 1'b0;
        bus1.out_ready = 1'b1;
        repeat (80) tick();
        check("rand_drained", 64'(bus1.out_valid), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/flatten_serializer.md
Name: flatten_serializer

Overview:
- Parametrised parallel-to-serial flatten stage. It sits between the per-channel global-average-pool units and the serial fully-connected/softmax unit.
- Captures one CH-wide vector of pooled channel values in a single cycle and streams the elements one per beat over a valid/ready interface.
- Successor to the fixed 32x8 single-buffer flatten logic. Adds:
  - generic width and channel count
  - ping-pong double buffering
  - downstream backpressure
  - last/index sideband
  - sticky overrun detection and a soft clear

Parameters:
- CH, 32, number of channel elements per vector; legal range CH >= 1.
- DW, 8, bits per element; legal range DW >= 1.
- IDX_W, $clog2(CH) with minimum 1, width of the element index (derived localparam).

Ports:
- clk  input  1  rising-edge clock (single clock domain)
- rst_n  input  1  asynchronous, active-low reset
- clear  input  1  synchronous soft clear; empties both banks and clears overrun
- in_valid  input  1  in_data holds a complete vector this cycle
- in_data  input  CH*DW  packed vector; element k = in_data[k*DW +: DW]
- in_ready  output  1  a bank is free; driven from registers only
- out_valid  output  1  out_data holds a valid element
- out_data  output  DW  current element
- out_index  output  IDX_W  position of the current element in its vector, 0..CH-1
- out_last  output  1  high on element CH-1
- out_ready  input  1  downstream accepts the element this cycle
- overrun  output  1  sticky flag: a vector was presented while no bank was free
- busy  output  1  at least one bank is full

Behaviour:
- Reset is asynchronous and active-low. On reset:
  - both banks are zeroed, the full flags and wr_bank/rd_bank are cleared, idx = 0
  - out_valid = 0, out_data = 0, out_index = 0, out_last = 0, overrun = 0, busy = 0, in_ready = 1
- Reset mid-stream aborts the stream immediately; the partially sent vector is discarded.
- Storage:
  - Two banks of CH x DW registers, each with a full flag.
  - wr_bank points at the next bank to fill; rd_bank points at the bank being streamed.
- in_ready = !full[wr_bank]. There is no combinational path from out_ready to in_ready.
- Capture happens when in_valid && in_ready && !clear:
  - bank[wr_bank] <= in_data
  - full[wr_bank] <= 1
  - wr_bank toggles
- Drop happens when in_valid && !in_ready && !clear:
  - the vector is discarded and overrun <= 1 (sticky)
  - it is not an error for upstream; the GAP stage cannot stall
- Output:
  - out_valid = full[rd_bank]
  - out_data = bank[rd_bank][idx]
  - out_index = idx
  - out_last = out_valid && (idx == CH-1)
  - All outputs come from registers through the element mux only.
- Latency: the first element of a vector is valid one cycle after its capture edge.
- Handshake (beat = out_valid && out_ready):
  - A non-last beat increments idx.
  - The last beat sets idx = 0, clears full[rd_bank] and toggles rd_bank.
  - If the other bank is already full, its element 0 appears the next cycle with no bubble.
- Stall: while out_valid && !out_ready, out_data, out_index and out_last hold stable.
- Throughput: CH beats per vector at out_ready = 1; sustained rate is one vector per CH cycles.
- Simultaneous events:
  - A capture into one bank and the last beat of the other bank in the same cycle are both performed.
  - A bank freed this cycle shows in_ready = 1 only from the next cycle.
- clear:
  - Sets all full flags, both pointers and idx to 0, and overrun = 0.
  - Has priority over capture and drop in the same cycle; the incoming vector is ignored and overrun is not set.
  - Bank contents are not zeroed.
- CH = 1: every beat has out_last = 1 and out_index = 0.
- busy = full[0] | full[1].
- Element order is 0 first (lowest slice), i.e. channel order matches the FC weight order.

Decomposition:
- Shared CNN package holds:
  - data-width constant 8
  - GAP channel count 32
  - FC input dimension 32
  - QUANT_SHIFT 8
  - a clog2-with-minimum-1 helper function
- Single module. The bank storage is a 2-D register array inside it; no sub-module is warranted.

Test Plan:
1. Reset, then present one vector with element k = k+1 (CH=32, DW=8) while out_ready = 1:
   - in_ready = 1 at capture; out_valid rises one cycle later
   - 32 consecutive beats with data 1..32 and out_index 0..31
   - out_last only on data 32; then out_valid = 0 and busy = 0
2. One vector, out_ready alternating 1/0 from the first beat:
   - data/index/last hold during every low cycle; 64 cycles to complete
   - values 1..32 in order, no duplicates
3. Two vectors on consecutive cycles (A: all 0x11, B: all 0x22), out_ready = 1:
   - both accepted
   - 64 beats with no gap; the first 0x22 beat directly follows the A beat with out_last = 1
4. out_ready = 0, then present vectors A, B, C:
   - A and B accepted; in_ready = 0 at C, C dropped, overrun = 1
   - release out_ready: only A then B stream
   - then pulse clear: overrun = 0, out_valid = 0, in_ready = 1
5. Assert rst_n = 0 at beat 10 of a stream:
   - outputs take reset values without waiting for a clock edge
   - after release, a new vector streams from out_index 0 with correct data
6. Instance CH=4, DW=16, in_data = {16'hABCD, 16'h0003, 16'h0002, 16'h0001}:
   - beats 0x0001, 0x0002, 0x0003, 0xABCD
   - out_last on 0xABCD, out_index width 2
